rtc_timekeeper: RTL and testbench

Parametrised next-generation wall-clock timekeeper. It divides the system clock down to a 1 Hz tick and keeps hours, minutes and seconds. Over the fixed-rate 24-hour counter it adds a programmable prescaler, a run/hold control, a validated time-load port, 12/24-hour display mode, a minute-resolution alarm and a day-rollover pulse. It sits between the system clock domain and the display/alarm logic.

---
 rtl/rtc_timekeeper_pkg.sv | 24 ++
 rtl/rtc_timekeeper_wrap_counter.sv | 28 ++
 rtl/rtc_timekeeper.sv | 102 ++++++++++
 tb/tb_rtc_timekeeper.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_timekeeper_pkg.sv
// Shared time-of-day constants, widths and the packed time record.
// Also provides the range check used to validate a time load.
package clock_pkg;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned HR_MAX  = 23;

  localparam int unsigned SEC_W = 6;
  localparam int unsigned MIN_W = 6;
  localparam int unsigned HR_W  = 5;

  typedef struct packed {
    logic [HR_W-1:0]  hr;
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
  } time_t;

  function automatic logic time_valid(input time_t t);
    return (t.hr <= HR_W'(HR_MAX)) && (t.min <= MIN_W'(MIN_MAX)) &&
           (t.sec <= SEC_W'(SEC_MAX));
  endfunction

endpackage

// File: rtl/rtc_timekeeper_wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous load; carry is high while the
// counter is incremented from MAX back to zero.
module wrap_counter #(
  parameter int unsigned MAX = 59,
  parameter int unsigned W   = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         carry
);

  assign carry = inc && (value == W'(MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= carry ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/rtc_timekeeper.sv
// Wall-clock timekeeper: prescaler to a 1 Hz advance, chained sec/min/hour
// counters, validated load, 12/24-hour display, minute alarm and day pulse.
module rtc_timekeeper
  import clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             mode_12h,
  input  logic             load,
  input  logic [HR_W-1:0]  set_hr,
  input  logic [MIN_W-1:0] set_min,
  input  logic [SEC_W-1:0] set_sec,
  input  logic             alarm_en,
  input  logic [HR_W-1:0]  alarm_hr,
  input  logic [MIN_W-1:0] alarm_min,
  output logic [SEC_W-1:0] sec,
  output logic [MIN_W-1:0] min,
  output logic [HR_W-1:0]  hr,
  output logic             pm,
  output logic             sec_tick,
  output logic             day_tick,
  output logic             alarm,
  output logic             load_err
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(TICKS_PER_SEC - 1);

  time_t        set_t, cur;
  logic [PW-1:0] pcnt;
  logic         set_ok, load_ok, wrap, adv;
  logic         sec_c, min_c, hr_c;
  logic [MIN_W-1:0] nxt_min;
  logic [HR_W-1:0]  nxt_hr;
  logic         alarm_hit;

  assign set_t   = '{hr: set_hr, min: set_min, sec: set_sec};
  assign set_ok  = time_valid(set_t);
  assign load_ok = load && set_ok;
  assign wrap    = run && (pcnt == PCNT_LAST);
  // An accepted load pre-empts the advance that would otherwise happen
  assign adv     = wrap && !load_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (load_ok) begin
      pcnt <= '0;
    end else if (run) begin
      pcnt <= wrap ? '0 : pcnt + 1'b1;
    end
  end

  wrap_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
    .clk(clk), .reset(reset), .inc(adv), .load(load_ok),
    .load_val(set_sec), .value(cur.sec), .carry(sec_c)
  );
  wrap_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .clk(clk), .reset(reset), .inc(sec_c), .load(load_ok),
    .load_val(set_min), .value(cur.min), .carry(min_c)
  );
  wrap_counter #(.MAX(HR_MAX), .W(HR_W)) u_hr (
    .clk(clk), .reset(reset), .inc(min_c), .load(load_ok),
    .load_val(set_hr), .value(cur.hr), .carry(hr_c)
  );

  // Alarm compares against the time the advance is about to produce
  always_comb begin
    nxt_min   = min_c ? '0 : cur.min + 1'b1;
    nxt_hr    = hr_c ? '0 : (min_c ? cur.hr + 1'b1 : cur.hr);
    alarm_hit = sec_c && alarm_en && (alarm_hr == nxt_hr) && (alarm_min == nxt_min);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_tick <= 1'b0;
      day_tick <= 1'b0;
      alarm    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      sec_tick <= adv;
      day_tick <= hr_c;
      alarm    <= alarm_hit;
      load_err <= load && !set_ok;
    end
  end

  always_comb begin
    sec = cur.sec;
    min = cur.min;
    pm  = (cur.hr >= HR_W'(12));
    hr  = cur.hr;
    if (mode_12h) begin
      if (cur.hr == '0)              hr = HR_W'(12);
      else if (cur.hr > HR_W'(12))   hr = cur.hr - HR_W'(12);
    end
  end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Two timekeepers (1 and 4 ticks per second) on shared inputs, checked every
// cycle against a seconds-of-day model, plus directed literal expectations.
module tb_rtc_timekeeper;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0, mode_12h = 1'b0, load = 1'b0, alarm_en = 1'b0;
  logic [4:0] set_hr = '0, alarm_hr = '0;
  logic [5:0] set_min = '0, set_sec = '0, alarm_min = '0;

  logic [5:0] o_sec[2], o_min[2];
  logic [4:0] o_hr[2];
  logic       o_pm[2], o_st[2], o_dt[2], o_al[2], o_le[2];

  int unsigned checks = 0, passes = 0;
  bit          chk_en = 1'b1;

  always #5 clk = ~clk;

  rtc_timekeeper #(.TICKS_PER_SEC(1)) dut_a (
    .clk(clk), .reset(reset), .run(run), .mode_12h(mode_12h), .load(load),
    .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec), .alarm_en(alarm_en),
    .alarm_hr(alarm_hr), .alarm_min(alarm_min), .sec(o_sec[0]), .min(o_min[0]),
    .hr(o_hr[0]), .pm(o_pm[0]), .sec_tick(o_st[0]), .day_tick(o_dt[0]),
    .alarm(o_al[0]), .load_err(o_le[0])
  );

  rtc_timekeeper #(.TICKS_PER_SEC(4)) dut_b (
    .clk(clk), .reset(reset), .run(run), .mode_12h(mode_12h), .load(load),
    .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec), .alarm_en(alarm_en),
    .alarm_hr(alarm_hr), .alarm_min(alarm_min), .sec(o_sec[1]), .min(o_min[1]),
    .hr(o_hr[1]), .pm(o_pm[1]), .sec_tick(o_st[1]), .day_tick(o_dt[1]),
    .alarm(o_al[1]), .load_err(o_le[1])
  );

  // Model: time kept as seconds since midnight, prescaler as a plain count
  int unsigned tps[2] = '{1, 4};
  int unsigned m_p[2], m_t[2];
  bit          m_st[2], m_dt[2], m_al[2], m_le[2];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_p[k] = 0; m_t[k] = 0;
        m_st[k] = 0; m_dt[k] = 0; m_al[k] = 0; m_le[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_st[k] = 0; m_dt[k] = 0; m_al[k] = 0; m_le[k] = 0;
        if (load && set_hr <= 23 && set_min <= 59 && set_sec <= 59) begin
          m_t[k] = set_hr * 3600 + set_min * 60 + set_sec;
          m_p[k] = 0;
        end else begin
          if (load) m_le[k] = 1;
          if (run) begin
            m_p[k]++;
            if (m_p[k] == tps[k]) begin
              m_p[k]  = 0;
              m_t[k]  = (m_t[k] + 1) % 86400;
              m_st[k] = 1;
              m_dt[k] = (m_t[k] == 0);
              m_al[k] = alarm_en && alarm_hr <= 23 && alarm_min <= 59 &&
                        m_t[k] == alarm_hr * 3600 + alarm_min * 60;
            end
          end
        end
      end
    end
  end

  function automatic logic [21:0] model_vec(input int k);
    int unsigned h, hd;
    h  = m_t[k] / 3600;
    hd = mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
    return {5'(hd), h >= 12, 6'((m_t[k] / 60) % 60), 6'(m_t[k] % 60),
            m_st[k], m_dt[k], m_al[k], m_le[k]};
  endfunction

  function automatic logic [21:0] dut_vec(input int k);
    return {o_hr[k], o_pm[k], o_min[k], o_sec[k], o_st[k], o_dt[k], o_al[k], o_le[k]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && chk_en) begin
      check("cycle_a {hr,pm,min,sec,st,dt,al,le}", 32'(dut_vec(0)), 32'(model_vec(0)));
      check("cycle_b {hr,pm,min,sec,st,dt,al,le}", 32'(dut_vec(1)), 32'(model_vec(1)));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input int h, input int m, input int s);
    set_hr = 5'(h); set_min = 6'(m); set_sec = 6'(s);
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  int unsigned hrs_in[5] = '{0, 11, 12, 13, 23};
  int unsigned hrs12[5]  = '{12, 11, 12, 1, 11};
  int unsigned pms[5]    = '{0, 0, 1, 1, 1};

  initial begin
    #2;
    check("reset_hr24", 32'(o_hr[0]), 0);
    check("reset_sec", 32'(o_sec[1]), 0);
    check("reset_pulses", 32'({o_st[0], o_dt[0], o_al[0], o_le[0]}), 0);
    #10;
    run = 1'b1;
    reset = 1'b1;
    for (int i = 1; i <= 120; i++) begin
      tick(1);
      if (i == 1) check("first_tick_a", 32'(o_st[0]), 1);
      if (i == 4) check("first_tick_b", 32'(o_st[1]), 1);
      if (i == 60) check("a_60 {min,sec}", 32'({o_min[0], o_sec[0]}), 32'({6'd1, 6'd0}));
      if (i == 120) begin
        check("a_120 {min,sec}", 32'({o_min[0], o_sec[0]}), 32'({6'd2, 6'd0}));
        check("b_120 sec", 32'(o_sec[1]), 30);
      end
    end

    run = 1'b0;
    do_load(23, 59, 59);
    check("b_load {hr,min,sec}", 32'({o_hr[1], o_min[1], o_sec[1]}), 32'({5'd23, 6'd59, 6'd59}));
    run = 1'b1;
    tick(3);
    check("b_pre_roll {sec,dt}", 32'({o_sec[1], o_dt[1]}), 32'({6'd59, 1'b0}));
    tick(1);
    check("b_roll {hr,min,sec,st,dt}", 32'({o_hr[1], o_min[1], o_sec[1], o_st[1], o_dt[1]}),
          32'({5'd0, 6'd0, 6'd0, 1'b1, 1'b1}));
    tick(1);
    check("b_roll_after dt", 32'(o_dt[1]), 0);

    run = 1'b0;
    do_load(25, 0, 0);
    check("bad_load le", 32'(o_le[1]), 1);
    check("bad_load time", 32'({o_hr[1], o_min[1], o_sec[1]}), 0);
    tick(1);
    check("bad_load le_drop", 32'(o_le[1]), 0);
    run = 1'b1;
    do_load(12, 30, 45);
    check("load_vs_adv a", 32'({o_hr[0], o_min[0], o_sec[0], o_st[0]}),
          32'({5'd12, 6'd30, 6'd45, 1'b0}));

    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_load(int'(hrs_in[i]), 0, 0);
      mode_12h = 1'b1;
      #1;
      check("mode12 {hr,pm}", 32'({o_hr[0], o_pm[0]}), 32'({5'(hrs12[i]), 1'(pms[i])}));
      mode_12h = 1'b0;
      #1;
      check("mode24 hr", 32'(o_hr[0]), hrs_in[i]);
    end

    alarm_en = 1'b1; alarm_hr = 5'd7; alarm_min = 6'd0;
    do_load(6, 59, 59);
    run = 1'b1;
    tick(1);
    check("alarm_fire a {hr,al}", 32'({o_hr[0], o_al[0]}), 32'({5'd7, 1'b1}));
    tick(1);
    check("alarm_once a", 32'(o_al[0]), 0);
    run = 1'b0;
    do_load(7, 0, 0);
    check("alarm_on_load a", 32'(o_al[0]), 0);
    alarm_en = 1'b0;
    do_load(6, 59, 59);
    run = 1'b1;
    tick(1);
    check("alarm_disabled a {hr,al}", 32'({o_hr[0], o_al[0]}), 32'({5'd7, 1'b0}));

    run = 1'b0;
    do_load(5, 10, 20);
    tick(10);
    check("hold a", 32'({o_hr[0], o_min[0], o_sec[0]}), 32'({5'd5, 6'd10, 6'd20}));
    check("hold b", 32'({o_hr[1], o_min[1], o_sec[1]}), 32'({5'd5, 6'd10, 6'd20}));
    run = 1'b1;
    tick(1);
    #1;
    reset = 1'b0;
    #1;
    check("async_rst a", 32'({o_hr[0], o_pm[0], o_min[0], o_sec[0], o_st[0]}), 0);
    mode_12h = 1'b1;
    #1;
    check("async_rst hr12", 32'(o_hr[1]), 12);
    mode_12h = 1'b0;
    tick(1);
    reset = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        alarm_en  = $urandom_range(0, 3) != 0;
        alarm_hr  = 5'($urandom_range(0, 24));
        alarm_min = 6'($urandom_range(0, 61));
      end
      mode_12h = $urandom_range(0, 7) == 0 ? ~mode_12h : mode_12h;
      run = $urandom_range(0, 5) != 0;
      load = $urandom_range(0, 11) == 0;
      if (load) begin
        if ($urandom_range(0, 3) == 0) begin
          set_hr = 5'($urandom); set_min = 6'($urandom); set_sec = 6'($urandom);
          if (set_hr > 23 || set_min > 59 || set_sec > 59) run = 1'b0;
        end else begin
          int unsigned tgt;
          tgt = (alarm_hr % 24) * 3600 + (alarm_min % 60) * 60;
          tgt = (tgt + 86400 - $urandom_range(0, 12)) % 86400;
          if ($urandom_range(0, 3) == 0) tgt = 86400 - $urandom_range(1, 6);
          set_hr = 5'(tgt / 3600); set_min = 6'((tgt / 60) % 60); set_sec = 6'(tgt % 60);
        end
      end
      tick(1);
    end
    load = 1'b0;
    tick(2);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
